// File: rtl/pll_reset_ctrl.sv
// pll_reset_ctrl
//
// Reset and lock supervisor for a PLL wrapper, clocked by the free-running
// PLL reference clock. It pulses the PLL reset, then waits for lock. If lock
// does not arrive in time, it retries. Once lock has held for a stable
// window, it releases the system reset. Losing lock while running restarts
// the PLL and counts the event. Running out of retries parks the block in a
// sticky fail state.
//
// Ports
//   refclk     in   PLL reference clock, sole clock
//   rst        in   asynchronous active-high reset
//   locked     in   PLL lock indication, asynchronous to refclk
//   pll_rst    out  reset to the PLL
//   sys_rst    out  downstream system reset, active-high
//   ready      out  lock stable, system released
//   fail       out  sticky, retry budget exhausted
//   retry_cnt  out  lock timeouts in the current lock sequence
//   loss_cnt   out  lock-loss events while running, saturates at 255
//
// State      | meaning
// -----------+---------------------------------------------------------
// PLL_RST    | PLL held in reset for RST_PULSE_CYCLES
// WAIT_LOCK  | PLL released, waiting up to LOCK_TIMEOUT_CYCLES for lock
// STABLE     | lock seen, must hold for LOCK_STABLE_CYCLES
// RUN        | system released, watching for lock loss
// FAIL       | retries exhausted, terminal until rst

module pll_reset_ctrl #(
    parameter int unsigned RST_PULSE_CYCLES    = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 100000,
    parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
    parameter int unsigned MAX_RETRIES         = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_cnt,
    output logic [7:0] loss_cnt
);

    localparam logic [19:0] RST_LAST    = 20'(RST_PULSE_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [19:0] STABLE_LAST = 20'(LOCK_STABLE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PLL_RST   = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [19:0] cnt, cnt_nxt;
    logic        sync_1, locked_s;
    logic [3:0]  retry_nxt;
    logic [7:0]  loss_nxt;
    logic        pll_rst_nxt, sys_rst_nxt, ready_nxt, fail_nxt;

    // Two-flop synchronizer; the FSM only ever looks at locked_s.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            sync_1   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_1   <= locked;
            locked_s <= sync_1;
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state     <= S_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
            retry_cnt <= '0;
            loss_cnt  <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pll_rst   <= pll_rst_nxt;
            sys_rst   <= sys_rst_nxt;
            ready     <= ready_nxt;
            fail      <= fail_nxt;
            retry_cnt <= retry_nxt;
            loss_cnt  <= loss_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        retry_nxt = retry_cnt;
        loss_nxt  = loss_cnt;

        case (state)
            S_PLL_RST: begin
                if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                // Lock takes priority over a coincident timeout.
                if (locked_s) begin
                    state_nxt = S_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_cnt == RETRY_MAX) begin
                        state_nxt = S_FAIL;
                    end else begin
                        retry_nxt = retry_cnt + 4'd1;
                        state_nxt = S_PLL_RST;
                    end
                end
            end
            S_STABLE: begin
                // A dropout here is a glitch: back to waiting with a fresh
                // timeout, without charging a retry.
                if (!locked_s) state_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_nxt = S_PLL_RST;
                    retry_nxt = '0;
                    if (loss_cnt != 8'hFF) loss_nxt = loss_cnt + 8'd1;
                end
            end
            S_FAIL: begin
                state_nxt = S_FAIL;
            end
            default: begin
                state_nxt = S_PLL_RST;
            end
        endcase

        // Shared counter restarts on every state change; it only runs in
        // the timed states so it cannot wrap while parked in RUN or FAIL.
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end else if (state == S_RUN || state == S_FAIL) begin
            cnt_nxt = cnt;
        end else begin
            cnt_nxt = cnt + 20'd1;
        end

        // Outputs are registered from the state being entered so they
        // change on the same edge as the state.
        pll_rst_nxt = 1'b0;
        sys_rst_nxt = 1'b1;
        ready_nxt   = 1'b0;
        fail_nxt    = 1'b0;
        case (state_nxt)
            S_PLL_RST: pll_rst_nxt = 1'b1;
            S_RUN: begin
                sys_rst_nxt = 1'b0;
                ready_nxt   = 1'b1;
            end
            S_FAIL:    fail_nxt = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Testbench for pll_reset_ctrl: directed scenarios with literal expectations
// plus randomized lock activity, all checked every cycle against a
// phase/time-remaining model of the supervisor.

module tb_pll_reset_ctrl;

    localparam int RP = 4;
    localparam int TO = 20;
    localparam int ST = 8;
    localparam int MR = 2;

    localparam int P_RST    = 0;
    localparam int P_WAIT   = 1;
    localparam int P_STABLE = 2;
    localparam int P_RUN    = 3;
    localparam int P_FAIL   = 4;

    logic       refclk = 1'b0;
    logic       rst    = 1'b1;
    logic       locked = 1'b0;
    logic       pll_rst, sys_rst, ready, fail;
    logic [3:0] retry_cnt;
    logic [7:0] loss_cnt;

    int checks   = 0;
    int failures = 0;

    pll_reset_ctrl #(
        .RST_PULSE_CYCLES   (RP),
        .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES (ST),
        .MAX_RETRIES        (MR)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .fail     (fail),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt)
    );

    always #5 refclk = ~refclk;

    // Model: which phase we are in, how many edges remain in it, and the
    // lock samples still in flight through the two-edge synchronizer delay.
    typedef struct packed {
        int       phase;
        int       left;
        int       tries;
        int       losses;
        bit [1:0] hist;
    } mstate_t;

    mstate_t m = '0;

    function automatic mstate_t model_reset();
        mstate_t r;
        r.phase  = P_RST;
        r.left   = RP;
        r.tries  = 0;
        r.losses = 0;
        r.hist   = 2'b00;
        return r;
    endfunction

    function automatic mstate_t model_step(input mstate_t s, input bit lk);
        mstate_t r;
        bit      seen;
        r      = s;
        seen   = s.hist[1];          // lock as sampled two edges ago
        r.hist = {s.hist[0], lk};
        case (s.phase)
            P_RST: begin
                r.left = s.left - 1;
                if (r.left == 0) begin
                    r.phase = P_WAIT;
                    r.left  = TO;
                end
            end
            P_WAIT: begin
                if (seen) begin
                    r.phase = P_STABLE;
                    r.left  = ST;
                end else begin
                    r.left = s.left - 1;
                    if (r.left == 0) begin
                        if (s.tries == MR) begin
                            r.phase = P_FAIL;
                        end else begin
                            r.tries = s.tries + 1;
                            r.phase = P_RST;
                            r.left  = RP;
                        end
                    end
                end
            end
            P_STABLE: begin
                if (!seen) begin
                    r.phase = P_WAIT;
                    r.left  = TO;
                end else begin
                    r.left = s.left - 1;
                    if (r.left == 0) r.phase = P_RUN;
                end
            end
            P_RUN: begin
                if (!seen) begin
                    r.phase  = P_RST;
                    r.left   = RP;
                    r.tries  = 0;
                    r.losses = (s.losses < 255) ? s.losses + 1 : 255;
                end
            end
            default: ;
        endcase
        return r;
    endfunction

    always @(posedge refclk or posedge rst) begin
        if (rst) m <= model_reset();
        else     m <= model_step(m, locked);
    end

    always @(negedge refclk) begin
        logic       e_pll, e_sys, e_rdy, e_fail;
        logic [3:0] e_retry;
        logic [7:0] e_loss;
        e_pll   = (m.phase == P_RST);
        e_sys   = (m.phase != P_RUN);
        e_rdy   = (m.phase == P_RUN);
        e_fail  = (m.phase == P_FAIL);
        e_retry = 4'(m.tries);
        e_loss  = 8'(m.losses);
        checks++;
        if ({pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt} !==
            {e_pll, e_sys, e_rdy, e_fail, e_retry, e_loss}) begin
            failures++;
            $display("FAIL model_cmp t=%0t got pll_rst=%b sys_rst=%b ready=%b fail=%b retry_cnt=%0d loss_cnt=%0d expected %b %b %b %b %0d %0d",
                     $time, pll_rst, sys_rst, ready, fail, retry_cnt, loss_cnt,
                     e_pll, e_sys, e_rdy, e_fail, e_retry, e_loss);
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_pll_rst"},   32'(pll_rst),   1);
        chk({name, "_sys_rst"},   32'(sys_rst),   1);
        chk({name, "_ready"},     32'(ready),     0);
        chk({name, "_fail"},      32'(fail),      0);
        chk({name, "_retry_cnt"}, 32'(retry_cnt), 0);
        chk({name, "_loss_cnt"},  32'(loss_cnt),  0);
    endtask

    // Counts refclk edges until the selected output takes value val
    // (sampled on the falling edge after each rising edge); -1 on timeout.
    task automatic edges_until(input int sel, input logic val, output int n);
        logic s;
        n = -1;
        for (int k = 1; k <= 400; k++) begin
            @(negedge refclk);
            case (sel)
                0:       s = pll_rst;
                1:       s = sys_rst;
                2:       s = ready;
                default: s = fail;
            endcase
            if (s === val) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge refclk);
        #1 rst = 1'b1;
        @(negedge refclk);
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (3) @(negedge refclk);
        check_reset_vals("reset");

        // 1: first lock after release
        rst = 1'b0;
        edges_until(0, 1'b0, n);
        chk("t1_pll_rst_width", n, RP);
        repeat (6) @(negedge refclk);
        locked = 1'b1;
        edges_until(2, 1'b1, n);
        chk("t1_release_after_first_lock_sample", n - 1, ST + 2);
        chk("t1_sys_rst_low", 32'(sys_rst), 0);
        chk("t1_retry_cnt", 32'(retry_cnt), 0);

        // 4: lock loss in RUN
        locked = 1'b0;
        edges_until(1, 1'b1, n);
        chk("t4_loss_latency", n, 3);
        chk("t4_ready_low", 32'(ready), 0);
        chk("t4_pll_rst_high", 32'(pll_rst), 1);
        chk("t4_loss_cnt", 32'(loss_cnt), 1);
        repeat (2) @(negedge refclk);
        locked = 1'b1;
        edges_until(0, 1'b0, n);
        chk("t4_pll_rst_tail", n, RP - 2);
        edges_until(2, 1'b1, n);
        chk("t4_relock_ready", n, ST + 1);

        // 5: saturate loss_cnt with randomized dropouts
        for (int i = 0; i < 255; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge refclk);
            locked = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge refclk);
            locked = 1'b1;
            edges_until(2, 1'b0, n);
            chk("t5_ready_dropped", 32'(n > 0), 1);
            edges_until(2, 1'b1, n);
            chk("t5_ready_back", 32'(n > 0), 1);
            if (i == 253) chk("t5_loss_at_255", 32'(loss_cnt), 255);
        end
        chk("t5_loss_saturated", 32'(loss_cnt), 255);

        // 6a: async reset in mid-STABLE
        locked = 1'b0;
        @(negedge refclk);
        locked = 1'b1;
        edges_until(0, 1'b1, n);
        chk("t6a_pll_rst_rise", n, 2);
        edges_until(0, 1'b0, n);
        chk("t6a_pll_rst_fall", n, RP);
        repeat (3) @(negedge refclk);
        chk("t6a_in_stable_sys_rst", 32'(sys_rst), 1);
        chk("t6a_in_stable_pll_rst", 32'(pll_rst), 0);
        @(posedge refclk);
        #2 rst = 1'b1;
        #1 check_reset_vals("t6a_async");

        // 3: glitch during STABLE
        @(negedge refclk);
        rst = 1'b0;
        edges_until(0, 1'b0, n);
        chk("t3_pll_rst_width", n, RP);
        repeat (6) @(negedge refclk);
        locked = 1'b0;
        repeat (3) @(negedge refclk);
        locked = 1'b1;
        edges_until(2, 1'b1, n);
        chk("t3_release_after_restore", n - 1, ST + 2);
        chk("t3_retry_cnt", 32'(retry_cnt), 0);

        // 2: no lock at all -> fail
        locked = 1'b0;
        do_reset();
        edges_until(3, 1'b1, n);
        chk("t2_fail_edges", n, (MR + 1) * (RP + TO));
        chk("t2_retry_cnt", 32'(retry_cnt), MR);
        chk("t2_sys_rst", 32'(sys_rst), 1);
        repeat (30) @(negedge refclk);
        chk("t2_fail_sticky", 32'(fail), 1);
        chk("t2_sys_rst_held", 32'(sys_rst), 1);

        // 6b: async reset out of FAIL
        @(posedge refclk);
        #2 rst = 1'b1;
        #1 check_reset_vals("t6b_async");

        // randomized lock activity with occasional resets
        @(negedge refclk);
        rst = 1'b0;
        for (int s = 0; s < 150; s++) begin
            locked = 1'($urandom_range(0, 1));
            repeat ($urandom_range(1, 40)) @(negedge refclk);
            if ($urandom_range(0, 29) == 0) begin
                #1 rst = 1'b1;
                @(negedge refclk);
                rst = 1'b0;
            end
        end

        @(negedge refclk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
